// File: rtl/fp_pkg.sv
// Shared constants and types for the 255-bit modular subtractor datapath.
// The field prime is 2^255 - 19.
package fp_pkg;

  localparam int FP_W     = 255;
  localparam int FP_TAG_W = 4;
  localparam int LAT_SUB  = 5;

  localparam logic [FP_W-1:0] FP_Q = {FP_W{1'b1}} - FP_W'(18);

  typedef struct packed {
    logic [FP_W-1:0]     data;
    logic [FP_TAG_W-1:0] tag;
    logic                err;
  } fp_tagged_t;

endpackage

// File: rtl/fp_res_fifo.sv
// In-order result FIFO with first-word fall-through. Overflow protection is
// the caller's job (credit-gated issue), so there is no full flag.
module fp_res_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  fp_tagged_t i_wr_data,
  input  logic       i_rd_en,
  output logic       o_empty,
  output fp_tagged_t o_rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fp_tagged_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_rd_en && !o_empty) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp_sub_issue.sv
// Credit-gated issue/collect stage around the fixed-latency fp_sub pipeline.
// Optional FP_SUB_RANGE_CHECK_EN adds out_err for operands >= FP_Q.
module fp_sub_issue
  import fp_pkg::*;
#(
  parameter int PIPE_LAT  = LAT_SUB,
  parameter int OUT_DEPTH = 8,
  parameter int TAG_W     = FP_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [FP_W-1:0]  pipe_a,
  output logic [FP_W-1:0]  pipe_b,
  input  logic [FP_W-1:0]  pipe_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_d,
`ifdef FP_SUB_RANGE_CHECK_EN
  output logic             out_err,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]               r_count;
  logic [FP_W-1:0]             r_pipe_a;
  logic [FP_W-1:0]             r_pipe_b;
  logic [PIPE_LAT:0]           r_vld_sh;
  logic [PIPE_LAT:0]           w_vld_nx;
  logic [PIPE_LAT:0][TAG_W-1:0] r_tag_sh;
  logic [PIPE_LAT:0][TAG_W-1:0] w_tag_nx;
  logic [PIPE_LAT:0]           r_err_sh;
  logic [PIPE_LAT:0]           w_err_nx;
  logic                        w_accept;
  logic                        w_pop;
  logic                        w_in_err;
  logic                        w_empty;
  fp_tagged_t                  w_wr_entry;
  fp_tagged_t                  w_head;

  assign in_ready = (r_count < CNT_MAX);
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

`ifdef FP_SUB_RANGE_CHECK_EN
  assign w_in_err = (in_a >= FP_Q) || (in_b >= FP_Q);
`else
  assign w_in_err = 1'b0;
`endif

  // Credits cover both in-flight requests and buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_a <= '0;
      r_pipe_b <= '0;
    end else if (w_accept) begin
      r_pipe_a <= in_a;
      r_pipe_b <= in_b;
    end
  end

  assign pipe_a = r_pipe_a;
  assign pipe_b = r_pipe_b;

  assign w_vld_nx[0] = w_accept;
  assign w_tag_nx[0] = in_tag;
  assign w_err_nx[0] = w_in_err;

  for (genvar gi = 1; gi <= PIPE_LAT; gi++) begin : g_stage
    assign w_vld_nx[gi] = r_vld_sh[gi-1];
    assign w_tag_nx[gi] = r_tag_sh[gi-1];
    assign w_err_nx[gi] = r_err_sh[gi-1];
  end

  // Tag/valid track matches fp_sub latency so stage PIPE_LAT lines up with pipe_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sh <= '0;
      r_tag_sh <= '0;
      r_err_sh <= '0;
    end else begin
      r_vld_sh <= w_vld_nx;
      r_tag_sh <= w_tag_nx;
      r_err_sh <= w_err_nx;
    end
  end

  // TAG_W is expected to equal FP_TAG_W, the width of the stored tag field.
  assign w_wr_entry.data = pipe_d;
  assign w_wr_entry.tag  = r_tag_sh[PIPE_LAT];
  assign w_wr_entry.err  = r_err_sh[PIPE_LAT];

  fp_res_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (r_vld_sh[PIPE_LAT]),
    .i_wr_data(w_wr_entry),
    .i_rd_en  (w_pop),
    .o_empty  (w_empty),
    .o_rd_data(w_head)
  );

  assign out_valid = !w_empty;
  assign out_d     = w_head.data;
  assign out_tag   = w_head.tag;

`ifdef FP_SUB_RANGE_CHECK_EN
  assign out_err = w_head.err;
`else
  logic w_unused_err;
  assign w_unused_err = w_head.err;
`endif

endmodule

// File: tb/tb_fp_sub_issue.sv
// Scoreboard bench for fp_sub_issue with a behavioural fp_sub pipeline model.
// Also exercises FP_SUB_RANGE_CHECK_EN when that macro is defined.
module tb_fp_sub_issue;
  import fp_pkg::*;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [FP_W-1:0]  in_a = '0;
  logic [FP_W-1:0]  in_b = '0;
  logic [3:0]       in_tag = '0;
  logic [FP_W-1:0]  pipe_a;
  logic [FP_W-1:0]  pipe_b;
  logic [FP_W-1:0]  pipe_d;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [FP_W-1:0]  out_d;
  logic [3:0]       out_tag;
`ifdef FP_SUB_RANGE_CHECK_EN
  logic             out_err;
`endif

  fp_sub_issue #(.PIPE_LAT(LAT), .OUT_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_d(pipe_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
`ifdef FP_SUB_RANGE_CHECK_EN
    .out_err(out_err),
`endif
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // fp_sub stand-in: 5 cycles from pipe_a/pipe_b update to pipe_d update.
  function automatic logic [FP_W-1:0] fp_sub_model(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    if (a >= b) return a - b;
    return a + (FP_Q - b);
  endfunction

  logic [FP_W-1:0] m_pipe [LAT];
  always @(posedge clk) begin
    m_pipe[0] <= fp_sub_model(pipe_a, pipe_b);
    for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
  end
  assign pipe_d = m_pipe[LAT-1];

  // Reference result: (a - b) mod q via wide arithmetic.
  function automatic logic [FP_W-1:0] exp_sub(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W+1:0] t;
    t = {2'b00, a} + {2'b00, FP_Q} - {2'b00, b};
    t = t % {2'b00, FP_Q};
    return t[FP_W-1:0];
  endfunction

  typedef struct {
    logic [FP_W-1:0] d;
    logic [3:0]      tag;
    logic            err;
    int              acc;
    int              avail;
  } exp_t;

  exp_t sb[$];

  // Push: an accept seen before edge cyc+1 becomes visible after edge cyc+1+LAT+1.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e.d     = exp_sub(in_a, in_b);
      e.tag   = in_tag;
      e.err   = (in_a >= FP_Q) || (in_b >= FP_Q);
      e.acc   = cyc + 1;
      e.avail = cyc + 1 + LAT + 1;
      sb.push_back(e);
    end
  end

  // Monitor: checks handshake state every cycle and compares each popped result.
  int   m_committed;
  logic m_exp_v;
  exp_t m_e;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      m_committed = 0;
      foreach (sb[i]) if (sb[i].acc <= cyc) m_committed++;
      m_exp_v = (sb.size() > 0) && (sb[0].avail <= cyc);
      chk("out_valid", {255'd0, out_valid}, {255'd0, m_exp_v});
      chk("in_ready", {255'd0, in_ready}, {255'd0, (m_committed < DEPTH)});
      if (m_exp_v && out_valid && out_ready) begin
        m_e = sb.pop_front();
        chk("out_tag", {252'd0, out_tag}, {252'd0, m_e.tag});
`ifdef FP_SUB_RANGE_CHECK_EN
        chk("out_err", {255'd0, out_err}, {255'd0, m_e.err});
`endif
        if (!m_e.err) chk("out_d", {1'b0, out_d}, {1'b0, m_e.d});
        $display("[TB] pop cyc=%0d tag=%0d d=%h", cyc, out_tag, out_d);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b, input logic [3:0] tag);
    logic acc;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 256'd1, 256'd0);
  endtask

  function automatic logic [FP_W-1:0] rand_fe();
    logic [FP_W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 32) | FP_W'($urandom);
    if (v >= FP_Q) v = v - FP_Q;
    return v;
  endfunction

  bit rnd_phase = 1'b0;
  initial begin
    wait (rnd_phase);
    while (rnd_phase) begin
      @(posedge clk);
      #1;
      if (rnd_phase) out_ready = ($urandom % 3) != 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FP_W-1:0] ra;
    logic [FP_W-1:0] rb;
    idle(3);
    rst = 1'b0;
    chk("rst_pipe_a", {1'b0, pipe_a}, 256'd0);
    chk("rst_pipe_b", {1'b0, pipe_b}, 256'd0);
    chk("rst_out_d", {1'b0, out_d}, 256'd0);
    chk("rst_out_tag", {252'd0, out_tag}, 256'd0);
`ifdef FP_SUB_RANGE_CHECK_EN
    chk("rst_out_err", {255'd0, out_err}, 256'd0);
`endif

    // Single request, then modular wrap-around cases.
    send(FP_W'(5), FP_W'(3), 4'd2);
    idle(10);
    send(FP_W'(3), FP_W'(5), 4'd1);
    send(FP_W'(0), FP_Q - FP_W'(1), 4'd3);
    idle(10);

    // Back-to-back stream.
    for (int i = 0; i < 20; i++) send(rand_fe(), rand_fe(), 4'(i % 16));
    idle(12);

    // Back-pressure: fill all credits, then release one.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(rand_fe(), rand_fe(), 4'(i));
    in_valid = 1'b1;
    in_a = rand_fe();
    in_b = rand_fe();
    in_tag = 4'd8;
    idle(15);
    chk("bp_ready_low", {255'd0, in_ready}, 256'd0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("bp_ready_after_pop", {255'd0, in_ready}, 256'd1);
    idle(1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(25);

    // Reset with requests still in flight.
    for (int i = 0; i < 3; i++) send(rand_fe(), rand_fe(), 4'(10 + i));
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_pipe_a", {1'b0, pipe_a}, 256'd0);
    idle(10);

`ifdef FP_SUB_RANGE_CHECK_EN
    send(FP_Q, FP_W'(1), 4'd5);
    send(FP_W'(7), FP_W'(7), 4'd6);
    idle(10);
`endif

    // Randomised traffic with random consumer back-pressure.
    rnd_phase = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 4) != 0) begin
        ra = rand_fe();
        rb = rand_fe();
`ifdef FP_SUB_RANGE_CHECK_EN
        if (($urandom % 16) == 0) ra = FP_Q + FP_W'($urandom % 19);
`endif
        send(ra, rb, 4'($urandom));
      end else begin
        idle(1);
      end
    end
    rnd_phase = 1'b0;
    idle(1);
    out_ready = 1'b1;
    for (int g = 0; g < 300 && sb.size() != 0; g++) idle(1);
    chk("drain_empty", 256'(sb.size()), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_sub_issue.md
Name: fp_sub_issue

Overview:
- Upstream issue/collect stage for the fixed-latency modular subtractor fp_sub, which computes (A − B) mod q on 255-bit operands.
- Accepts operand pairs through a valid/ready interface and drives the non-stallable fp_sub pipeline.
- Realigns each pipeline result with its request tag and buffers results in an in-order output FIFO.
- Issue is credit-gated, so a result is never dropped when the consumer back-pressures.

Parameters:
- PIPE_LAT, 5, cycles from pipe_a/pipe_b update to the matching pipe_d update (fp_sub as built = 5)
- OUT_DEPTH, 8, output FIFO entries; also the total credit count (power of 2, ≥ 2)
- TAG_W, 4, request tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at the clock edge
- in_a  in  255  minuend, must be < q
- in_b  in  255  subtrahend, must be < q
- in_tag  in  TAG_W  opaque request tag
- pipe_a  out  255  to fp_sub A, registered
- pipe_b  out  255  to fp_sub B, registered
- pipe_d  in  255  from fp_sub D
- out_valid  out  1  result available (FIFO not empty)
- out_ready  in  1  consumer pop
- out_d  out  255  result, equal to (in_a − in_b) mod q
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - in_ready = 1, out_valid = 0, out_d = 0, out_tag = 0, pipe_a = 0, pipe_b = 0.
  - Credit count = 0, FIFO read/write pointers = 0, all tag/valid stages cleared.
- Credit count: in-flight requests plus FIFO occupancy, range 0..OUT_DEPTH.
  - in_ready = (count < OUT_DEPTH), decoded from registered state only; it never depends combinationally on out_ready.
  - Accept: count +1. Pop (out_valid && out_ready): count −1. Both in the same cycle: count unchanged.
- Issue: on accept, pipe_a/pipe_b load in_a/in_b. Otherwise they hold their previous values; fp_sub output is ignored when not tagged valid.
- Tag/valid shift register: stages 0..PIPE_LAT.
  - Stage 0 loads {accept, in_tag} every edge.
  - Stage k loads stage k−1 every edge.
- Capture: when stage PIPE_LAT is valid, the FIFO writes {pipe_d, tag} at that edge.
- Latency: accept at edge N → FIFO write at edge N+PIPE_LAT+1 → out_valid high from that edge onward (6 edges with defaults).
- Throughput: one request per cycle sustained while out_ready = 1.
- Ordering: results leave in strict request order.
- FIFO:
  - Circular buffer with log2(OUT_DEPTH)+1-bit pointers (wrap bit included).
  - out_d/out_tag show the head entry, first-word fall-through.
  - Credits guarantee the FIFO never overflows; the write occurs regardless of a simultaneous pop.
- Boundaries:
  - count = OUT_DEPTH → in_ready = 0. It returns to 1 the cycle after the first pop.
  - FIFO empty with a same-cycle write → out_valid rises the next cycle; no bypass path.
  - Reset mid-operation clears all stages and the FIFO, so in-flight results are discarded. Stale fp_sub output after reset is never captured.
- Arithmetic: none in this block. The modulus q lives in the shared package.

Optional Feature:
- Macro: FP_SUB_RANGE_CHECK_EN.
- When defined:
  - Adds output port out_err (1 bit), carried through the tag stages and FIFO alongside the tag.
  - out_err = 1 when the accepted in_a ≥ q or in_b ≥ q; the result is still issued.
  - out_err resets to 0.
- When undefined: no out_err port and no comparators; operands are trusted.

Decomposition:
- Package fp_pkg:
  - FP_W = 255 and constant FP_Q (the field prime).
  - Default LAT_SUB = 5.
  - Struct type fp_tagged_t {data[254:0], tag, err}.
- One sub-module: fp_res_fifo, the credit-free circular FIFO with first-word fall-through.
- The shift register and credit counter stay inline.

Test Plan:
- Single request: a=5, b=3, tag=2, out_ready=1 → out_valid exactly 6 edges after accept, out_d=2, out_tag=2.
- Wrap-around: a=3, b=5 → out_d = FP_Q−2. Also a=0, b=FP_Q−1 → out_d=1.
- Back-to-back: 20 consecutive requests with tags 0..15,0..3, out_ready=1 → in_ready stays 1; results appear in order on consecutive cycles.
- Back-pressure: out_ready=0, in_valid=1 held → exactly 8 accepts, then in_ready=0. After the 8 results are buffered, one pop → in_ready=1 next cycle and the 9th accept proceeds. No loss or reorder.
- Reset mid-flight: 3 requests accepted, rst asserted 2 cycles later for 1 cycle → out_valid stays 0 for 10 cycles after reset and in_ready=1.
- With FP_SUB_RANGE_CHECK_EN defined: a=FP_Q, b=1 → out_err=1. Then a=7, b=7 → out_d=0, out_err=0.
